alu_muldiv_unit: RTL and testbench

//  Parametrised execute-stage ALU with registered output and a valid/ready handshake.

---
 rtl/alu_muldiv_unit_if.sv | 30 +++
 rtl/alu_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// Operation bus for alu_muldiv_unit: valid/ready issue side plus registered results.
interface alu_muldiv_unit_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) ();
  logic               i_Valid;
  logic               o_Ready;
  logic [4:0]         i_Control;
  logic [WIDTH-1:0]   i_Data_1;
  logic [WIDTH-1:0]   i_Data_2;
  logic [SHAMT_W-1:0] i_Shamt;
  logic               i_Flush;
  logic               o_Valid;
  logic [WIDTH-1:0]   o_ALU_Result;
  logic [WIDTH-1:0]   o_HI;
  logic [WIDTH-1:0]   o_LO;
  logic               o_Div_Zero;

  // Issuing side (pipeline / testbench)
  modport master (
    output i_Valid, i_Control, i_Data_1, i_Data_2, i_Shamt, i_Flush,
    input  o_Ready, o_Valid, o_ALU_Result, o_HI, o_LO, o_Div_Zero
  );

  // Execution unit side
  modport slave (
    input  i_Valid, i_Control, i_Data_1, i_Data_2, i_Shamt, i_Flush,
    output o_Ready, o_Valid, o_ALU_Result, o_HI, o_LO, o_Div_Zero
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU with registered result, HI/LO registers and an iterative
// shift-add multiplier / restoring divider sharing one accumulator pair.
module alu_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  alu_muldiv_unit_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  typedef enum logic [4:0] {
    OP_SLL   = 5'd0,
    OP_SRL   = 5'd1,
    OP_SRA   = 5'd2,
    OP_SLLV  = 5'd3,
    OP_SRLV  = 5'd4,
    OP_SRAV  = 5'd5,
    OP_ADDU  = 5'd6,
    OP_SUBU  = 5'd7,
    OP_AND   = 5'd8,
    OP_OR    = 5'd9,
    OP_XOR   = 5'd10,
    OP_NOR   = 5'd11,
    OP_SLT   = 5'd12,
    OP_JALR  = 5'd13,
    OP_LUI   = 5'd14,
    OP_SLTU  = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_MFHI  = 5'd20,
    OP_MFLO  = 5'd21,
    OP_MTHI  = 5'd22,
    OP_MTLO  = 5'd23
  } op_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc_hi: partial product high half / partial remainder
  // acc_lo: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand / divisor magnitude
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;         // negate product / quotient
  logic             rem_neg_q, rem_neg_d; // negate remainder
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;
  logic             div_zero_q, div_zero_d;

  op_e              op;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] vshamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic             is_signed;
  logic             sign_1, sign_2;
  logic [WIDTH-1:0] mag_1, mag_2;

  assign op     = op_e'(bus.i_Control);
  assign ready  = (state_q == S_IDLE);
  assign accept = bus.i_Valid & ready & ~bus.i_Flush;
  assign vshamt = bus.i_Data_1[SHAMT_W-1:0];

  // Operand signs and magnitudes for the iterative datapath
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    sign_1    = is_signed & bus.i_Data_1[WIDTH-1];
    sign_2    = is_signed & bus.i_Data_2[WIDTH-1];
    mag_1     = sign_1 ? -bus.i_Data_1 : bus.i_Data_1;
    mag_2     = sign_2 ? -bus.i_Data_2 : bus.i_Data_2;
  end

  // Single-cycle ALU result
  always_comb begin
    alu_res = '0;
    case (op)
      OP_SLL:  alu_res = bus.i_Data_2 << bus.i_Shamt;
      OP_SRL:  alu_res = bus.i_Data_2 >> bus.i_Shamt;
      OP_SRA:  alu_res = $unsigned($signed(bus.i_Data_2) >>> bus.i_Shamt);
      OP_SLLV: alu_res = bus.i_Data_2 << vshamt;
      OP_SRLV: alu_res = bus.i_Data_2 >> vshamt;
      OP_SRAV: alu_res = $unsigned($signed(bus.i_Data_2) >>> vshamt);
      OP_ADDU: alu_res = bus.i_Data_1 + bus.i_Data_2;
      OP_SUBU: alu_res = bus.i_Data_1 - bus.i_Data_2;
      OP_AND:  alu_res = bus.i_Data_1 & bus.i_Data_2;
      OP_OR:   alu_res = bus.i_Data_1 | bus.i_Data_2;
      OP_XOR:  alu_res = bus.i_Data_1 ^ bus.i_Data_2;
      OP_NOR:  alu_res = ~(bus.i_Data_1 | bus.i_Data_2);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.i_Data_1) < $signed(bus.i_Data_2))};
      OP_JALR: alu_res = bus.i_Data_1 + WIDTH'(1);
      OP_LUI:  alu_res = bus.i_Data_2 << (WIDTH / 2);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.i_Data_1 < bus.i_Data_2)};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step and one restoring-division step on the accumulators
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_qbit  = ~div_diff[WIDTH];
    div_hi_nx = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_nx = {acc_lo_q[WIDTH-2:0], div_qbit};
  end

  // Sign correction of the finished magnitudes
  always_comb begin
    prod_mag = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod_mag : prod_mag;
    quo_fix  = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;
  end

  // Next-state and register-update logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    op_div_d   = op_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    valid_d    = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              acc_hi_d = '0;
              acc_lo_d = mag_1;
              opnd_d   = mag_2;
              neg_d    = sign_1 ^ sign_2;
              op_div_d = 1'b0;
              cnt_d    = CNT_LAST;
              state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.i_Data_2 == '0) begin
                hi_d       = bus.i_Data_1;
                lo_d       = '1;
                result_d   = '1;
                valid_d    = 1'b1;
                div_zero_d = 1'b1;
              end else begin
                acc_hi_d  = '0;
                acc_lo_d  = mag_1;
                opnd_d    = mag_2;
                neg_d     = sign_1 ^ sign_2;
                rem_neg_d = sign_1;
                op_div_d  = 1'b1;
                cnt_d     = CNT_LAST;
                state_d   = S_DIV;
              end
            end
            OP_MTHI: begin
              hi_d     = bus.i_Data_1;
              result_d = '0;
              valid_d  = 1'b1;
            end
            OP_MTLO: begin
              lo_d     = bus.i_Data_1;
              result_d = '0;
              valid_d  = 1'b1;
            end
            default: begin
              result_d = alu_res;
              valid_d  = 1'b1;
            end
          endcase
        end
      end

      S_MUL, S_DIV: begin
        if (bus.i_Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = (state_q == S_MUL) ? mul_hi_nx : div_hi_nx;
          acc_lo_d = (state_q == S_MUL) ? mul_lo_nx : div_lo_nx;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        if (!bus.i_Flush) begin
          if (op_div_q) begin
            hi_d     = rem_fix;
            lo_d     = quo_fix;
            result_d = quo_fix;
          end else begin
            hi_d     = prod_fix[2*WIDTH-1:WIDTH];
            lo_d     = prod_fix[WIDTH-1:0];
            result_d = prod_fix[WIDTH-1:0];
          end
          valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      op_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      op_div_q   <= op_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.o_Ready      = ready;
  assign bus.o_Valid      = valid_q;
  assign bus.o_ALU_Result = result_q;
  assign bus.o_HI         = hi_q;
  assign bus.o_LO         = lo_q;
  assign bus.o_Div_Zero   = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed self-checking bench for alu_muldiv_unit (WIDTH=32).
module tb_alu_muldiv_unit;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int TMO     = 100;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  alu_muldiv_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    bus.i_Valid   = v;
    bus.i_Control = c;
    bus.i_Data_1  = a;
    bus.i_Data_2  = b;
    bus.i_Shamt   = sh;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
  endtask

  // Advance negedges until o_Valid is seen or the budget runs out
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.o_Valid !== 1'b1 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.o_Ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", bus.o_Ready); else n_pass++;
    n_total++;
    if (bus.o_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.o_Valid); else n_pass++;
    n_total++;
    if (bus.o_ALU_Result !== 32'h0) $display("FAIL reset_result: got %h expected 0", bus.o_ALU_Result); else n_pass++;
    n_total++;
    if (bus.o_HI !== 32'h0 || bus.o_LO !== 32'h0)
      $display("FAIL reset_hilo: got %h/%h expected 0/0", bus.o_HI, bus.o_LO); else n_pass++;
    n_total++;
    if (bus.o_Div_Zero !== 1'b0) $display("FAIL reset_divz: got %b expected 0", bus.o_Div_Zero); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd6, 32'd7, 32'd5, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'd12)
      $display("FAIL b2b_addu: got v=%b %h expected v=1 0000000c", bus.o_Valid, bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd7, 32'd0, 32'd1, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'hFFFF_FFFF)
      $display("FAIL b2b_subu: got v=%b %h expected v=1 ffffffff", bus.o_Valid, bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd2, 32'd0, 32'h8000_0000, 5'd4);
    @(negedge clk);
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'hF800_0000)
      $display("FAIL b2b_sra: got v=%b %h expected v=1 f8000000", bus.o_Valid, bus.o_ALU_Result); else n_pass++;
    idle();
    @(negedge clk);
    n_total++;
    if (bus.o_Valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b expected 0", bus.o_Valid); else n_pass++;
  endtask

  task automatic test_mult();
    int ready_low;
    int valid_at;
    int valid_cnt;
    int cyc;
    ready_low = 0;
    valid_at  = -1;
    valid_cnt = 0;
    drive(1'b1, 5'd16, 32'hFFFF_FFFE, 32'd3, 5'd0);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      idle();
      if (bus.o_Ready === 1'b0) ready_low++;
      if (bus.o_Valid === 1'b1) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = n;
          n_total++;
          if (bus.o_HI !== 32'hFFFF_FFFF || bus.o_LO !== 32'hFFFF_FFFA || bus.o_ALU_Result !== 32'hFFFF_FFFA)
            $display("FAIL mult_hilo: got %h/%h res %h expected ffffffff/fffffffa res fffffffa",
                     bus.o_HI, bus.o_LO, bus.o_ALU_Result);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (ready_low !== 33) $display("FAIL mult_ready_low: got %0d expected 33", ready_low); else n_pass++;
    n_total++;
    if (valid_at !== 33) $display("FAIL mult_latency: got %0d expected 33", valid_at); else n_pass++;
    n_total++;
    if (valid_cnt !== 1) $display("FAIL mult_valid_count: got %0d expected 1", valid_cnt); else n_pass++;

    drive(1'b1, 5'd17, 32'hFFFF_FFFE, 32'd3, 5'd0);
    @(negedge clk);
    idle();
    wait_valid(cyc);
    n_total++;
    if (cyc >= TMO || bus.o_HI !== 32'd2 || bus.o_LO !== 32'hFFFF_FFFA)
      $display("FAIL multu_hilo: got %h/%h (wait %0d) expected 00000002/fffffffa", bus.o_HI, bus.o_LO, cyc);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div();
    int cyc;
    drive(1'b1, 5'd18, 32'hFFFF_FFF9, 32'd2, 5'd0);
    @(negedge clk);
    idle();
    wait_valid(cyc);
    n_total++;
    if (cyc >= TMO || bus.o_LO !== 32'hFFFF_FFFD || bus.o_HI !== 32'hFFFF_FFFF || bus.o_ALU_Result !== 32'hFFFF_FFFD)
      $display("FAIL div_neg: got lo %h hi %h res %h expected fffffffd ffffffff fffffffd",
               bus.o_LO, bus.o_HI, bus.o_ALU_Result);
    else n_pass++;
    @(negedge clk);

    drive(1'b1, 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    @(negedge clk);
    idle();
    wait_valid(cyc);
    n_total++;
    if (cyc >= TMO || bus.o_LO !== 32'h8000_0000 || bus.o_HI !== 32'h0)
      $display("FAIL div_minneg: got lo %h hi %h expected 80000000 00000000", bus.o_LO, bus.o_HI);
    else n_pass++;
    @(negedge clk);

    drive(1'b1, 5'd19, 32'd100, 32'd7, 5'd0);
    @(negedge clk);
    idle();
    wait_valid(cyc);
    n_total++;
    if (cyc >= TMO || bus.o_LO !== 32'd14 || bus.o_HI !== 32'd2)
      $display("FAIL divu: got lo %h hi %h expected 0000000e 00000002", bus.o_LO, bus.o_HI);
    else n_pass++;
    @(negedge clk);

    drive(1'b1, 5'd20, 32'd0, 32'd0, 5'd0);
    @(negedge clk);
    idle();
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'd2)
      $display("FAIL mfhi: got v=%b %h expected v=1 00000002", bus.o_Valid, bus.o_ALU_Result); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    drive(1'b1, 5'd19, 32'd5, 32'd0, 5'd0);
    @(negedge clk);
    idle();
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_Div_Zero !== 1'b1 || bus.o_Ready !== 1'b1)
      $display("FAIL divz_flags: got v=%b dz=%b rdy=%b expected 1 1 1", bus.o_Valid, bus.o_Div_Zero, bus.o_Ready);
    else n_pass++;
    n_total++;
    if (bus.o_HI !== 32'd5 || bus.o_LO !== 32'hFFFF_FFFF || bus.o_ALU_Result !== 32'hFFFF_FFFF)
      $display("FAIL divz_values: got hi %h lo %h res %h expected 00000005 ffffffff ffffffff",
               bus.o_HI, bus.o_LO, bus.o_ALU_Result);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.o_Div_Zero !== 1'b0 || bus.o_Valid !== 1'b0)
      $display("FAIL divz_pulse: got dz=%b v=%b expected 0 0", bus.o_Div_Zero, bus.o_Valid); else n_pass++;
  endtask

  task automatic test_flush();
    int vseen;
    vseen = 0;
    drive(1'b1, 5'd16, 32'd3, 32'd4, 5'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      idle();
      if (bus.o_Valid === 1'b1) vseen++;
    end
    bus.i_Flush = 1'b1;
    @(negedge clk);
    bus.i_Flush = 1'b0;
    n_total++;
    if (bus.o_Ready !== 1'b1 || bus.o_Valid !== 1'b0)
      $display("FAIL flush_ready: got rdy=%b v=%b expected 1 0", bus.o_Ready, bus.o_Valid); else n_pass++;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (bus.o_Valid === 1'b1) vseen++;
    end
    n_total++;
    if (vseen !== 0) $display("FAIL flush_no_valid: got %0d pulses expected 0", vseen); else n_pass++;
    n_total++;
    if (bus.o_HI !== 32'd5 || bus.o_LO !== 32'hFFFF_FFFF)
      $display("FAIL flush_hilo: got %h/%h expected 00000005/ffffffff", bus.o_HI, bus.o_LO); else n_pass++;

    drive(1'b1, 5'd6, 32'd1, 32'd1, 5'd0);
    bus.i_Flush = 1'b1;
    @(negedge clk);
    bus.i_Flush = 1'b0;
    idle();
    n_total++;
    if (bus.o_Valid !== 1'b0) $display("FAIL flush_idle_drop: got v=%b expected 0", bus.o_Valid); else n_pass++;
  endtask

  task automatic test_misc_ops();
    drive(1'b1, 5'd22, 32'h0000_1234, 32'd0, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'h0 || bus.o_HI !== 32'h0000_1234)
      $display("FAIL mthi: got v=%b res %h hi %h expected 1 00000000 00001234", bus.o_Valid, bus.o_ALU_Result, bus.o_HI);
    else n_pass++;
    drive(1'b1, 5'd12, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_ALU_Result !== 32'd1) $display("FAIL slt: got %h expected 00000001", bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd15, 32'hFFFF_FFFF, 32'd1, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_ALU_Result !== 32'd0) $display("FAIL sltu: got %h expected 00000000", bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd14, 32'd0, 32'h0000_1234, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_ALU_Result !== 32'h1234_0000) $display("FAIL lui: got %h expected 12340000", bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd5, 32'hFFFF_FFE4, 32'h8000_0000, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_ALU_Result !== 32'hF800_0000) $display("FAIL srav: got %h expected f8000000", bus.o_ALU_Result); else n_pass++;
    drive(1'b1, 5'd13, 32'hFFFF_FFFF, 32'd0, 5'd0);
    @(negedge clk);
    n_total++;
    if (bus.o_ALU_Result !== 32'h0) $display("FAIL jalr_wrap: got %h expected 00000000", bus.o_ALU_Result); else n_pass++;
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd19, 32'd100, 32'd7, 5'd0);
    @(negedge clk);
    idle();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (bus.o_Ready !== 1'b1 || bus.o_Valid !== 1'b0 || bus.o_Div_Zero !== 1'b0)
      $display("FAIL rst_mid_ctrl: got rdy=%b v=%b dz=%b expected 1 0 0", bus.o_Ready, bus.o_Valid, bus.o_Div_Zero);
    else n_pass++;
    n_total++;
    if (bus.o_HI !== 32'h0 || bus.o_LO !== 32'h0 || bus.o_ALU_Result !== 32'h0)
      $display("FAIL rst_mid_data: got hi %h lo %h res %h expected 0 0 0", bus.o_HI, bus.o_LO, bus.o_ALU_Result);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    n_total++;
    if (bus.o_HI !== 32'h0 || bus.o_LO !== 32'h0)
      $display("FAIL rst_mid_lost: got %h/%h expected 0/0", bus.o_HI, bus.o_LO); else n_pass++;
  endtask

  task automatic test_reserved();
    drive(1'b1, 5'd6, 32'd1, 32'd1, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    @(negedge clk);
    idle();
    n_total++;
    if (bus.o_Valid !== 1'b1 || bus.o_ALU_Result !== 32'h0)
      $display("FAIL reserved: got v=%b %h expected v=1 00000000", bus.o_Valid, bus.o_ALU_Result); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_Flush = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_back_to_back();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_misc_ops();
    test_reset_mid();
    test_reserved();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
